alu_rs_issue: RTL and testbench

- Storage and issue side of the 4-entry ALU reservation station.
- Accepts the one-hot entry write produced by the decode-stage RS arbiter.
- Captures operands from the common data bus (CDB) as they become available.
- Selects one ready entry per cycle and hands it to the ALU over a valid/ready handshake; exports the busy vector back to the arbiter.

---
 rtl/rs_pkg.sv | 42 ++++
 rtl/rs_age_matrix.sv | 60 ++++++
 rtl/alu_rs_issue.sv | 158 +++++++++++++++
 tb/tb_alu_rs_issue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg -- shared reservation-station definitions.
//   rs_entry_t   : one station entry (busy, opcode, dest tag, two operands
//                  with their producer tags and ready bits)
//   ALU_ENTRIES  : number of ALU station entries
//   TAG_W/OP_W/DATA_W : ROB tag, opcode and operand widths
//   rs_station_e : station identifiers used by the decode-stage arbiter
//   tag_hit()    : operand wakeup test against a CDB broadcast
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int ALU_ENTRIES = 4;
    localparam int TAG_W       = 4;
    localparam int OP_W        = 4;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        RS_ALU    = 2'b00,
        RS_BRANCH = 2'b01
    } rs_station_e;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic              rdy1;
        logic              rdy2;
    } rs_entry_t;

    // True when a waiting operand's producer tag matches a valid broadcast.
    function automatic logic tag_hit(input logic             rdy,
                                     input logic [TAG_W-1:0] tag,
                                     input logic             cdb_valid,
                                     input logic [TAG_W-1:0] cdb_tag);
        return !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// ---------------------------------------------------------------------------
// rs_age_matrix -- write-order tracker for the ALU reservation station.
// Only instantiated when RS_AGE_ORDER_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wr_onehot    : entry accepted for write this cycle (one-hot or zero)
//   issue_onehot : entry issued this cycle (one-hot or zero)
//   eligible     : entries ready to issue
//   oldest       : one-hot oldest eligible entry (zero when none eligible)
// ---------------------------------------------------------------------------
module rs_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] wr_onehot,
    input  logic [N-1:0] issue_onehot,
    input  logic [N-1:0] eligible,
    output logic [N-1:0] oldest
);

    // older[i][j] = 1 : entry j was written before entry i.
    logic [N-1:0] older [N];
    logic [N-1:0] cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) older[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_onehot[i]) begin
                    older[i] <= '1;
                end else begin
                    for (int unsigned j = 0; j < N; j++)
                        if (wr_onehot[j] || issue_onehot[j]) older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cand   = '0;
        oldest = '0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [N-1:0] others;
            others    = '1;
            others[i] = 1'b0;
            cand[i]   = eligible[i] && ((older[i] & eligible & others) == '0);
        end
        // Lowest-index tie break keeps the result one-hot even if the
        // matrix held stale relations.
        for (int unsigned i = N; i > 0; i--) begin
            if (cand[i-1]) begin
                oldest      = '0;
                oldest[i-1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_issue.sv
// ---------------------------------------------------------------------------
// alu_rs_issue -- storage and issue side of the 4-entry ALU reservation
// station. Entries are written by the decode-stage arbiter (one-hot select),
// wake up from CDB broadcasts, and one eligible entry per cycle is offered
// to the ALU over a valid/ready handshake.
// Build option: RS_AGE_ORDER_EN -- oldest eligible entry issues (age
// matrix); undefined -> lowest-index eligible entry issues.
// Ports:
//   clk, reset, flush          : clock, sync active-high reset, flush
//   ALURequests                : one-hot entry write select
//   wrOp/wrDest/wrVal*/wrTag*/wrRdy* : incoming instruction fields
//   cdbValid/cdbTag/cdbData    : common data bus broadcast
//   ALUBusyVector              : per-entry busy, back to the arbiter
//   issueValid/issueReady      : issue handshake
//   issueOp/issueSrc*/issueDest: selected entry fields
//   issueIdx                   : one-hot selected entry
// ---------------------------------------------------------------------------
module alu_rs_issue
    import rs_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int ALU   = 3,
    parameter int TAG   = 3,
    parameter int OPW   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic [ALU:0]   ALURequests,
    input  logic [OPW:0]   wrOp,
    input  logic [TAG:0]   wrDest,
    input  logic [WIDTH:0] wrVal1,
    input  logic [WIDTH:0] wrVal2,
    input  logic [TAG:0]   wrTag1,
    input  logic [TAG:0]   wrTag2,
    input  logic           wrRdy1,
    input  logic           wrRdy2,
    input  logic           cdbValid,
    input  logic [TAG:0]   cdbTag,
    input  logic [WIDTH:0] cdbData,
    output logic [ALU:0]   ALUBusyVector,
    output logic           issueValid,
    input  logic           issueReady,
    output logic [OPW:0]   issueOp,
    output logic [WIDTH:0] issueSrc1,
    output logic [WIDTH:0] issueSrc2,
    output logic [TAG:0]   issueDest,
    output logic [ALU:0]   issueIdx
);

    localparam int N = ALU + 1;

    rs_entry_t    ent [N];
    logic [N-1:0] busy_vec;
    logic [N-1:0] eligible;
    logic [N-1:0] sel;
    logic [N-1:0] wr_accept;
    logic         fire;

    always_comb begin
        busy_vec = '0;
        eligible = '0;
        for (int unsigned i = 0; i < N; i++) begin
            busy_vec[i] = ent[i].busy;
            eligible[i] = ent[i].busy && ent[i].rdy1 && ent[i].rdy2;
        end
    end

    assign wr_accept     = (reset || flush) ? '0 : (ALURequests & ~busy_vec);
    assign ALUBusyVector = busy_vec;
    assign issueValid    = |eligible;
    assign fire          = issueValid && issueReady;
    assign issueIdx      = sel;

`ifdef RS_AGE_ORDER_EN
    rs_age_matrix #(
        .N(N)
    ) u_age (
        .clk          (clk),
        .reset        (reset),
        .wr_onehot    (wr_accept),
        .issue_onehot (fire ? sel : '0),
        .eligible     (eligible),
        .oldest       (sel)
    );
`else
    always_comb begin
        sel = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (eligible[i-1]) begin
                sel      = '0;
                sel[i-1] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        issueOp   = '0;
        issueSrc1 = '0;
        issueSrc2 = '0;
        issueDest = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel[i]) begin
                issueOp   = ent[i].op;
                issueSrc1 = ent[i].val1;
                issueSrc2 = ent[i].val2;
                issueDest = ent[i].dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < N; i++) begin
                ent[i].busy <= 1'b0;
                ent[i].rdy1 <= 1'b0;
                ent[i].rdy2 <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_accept[i]) begin
                    // Operand whose producer broadcasts this very cycle is
                    // captured from the CDB instead of waiting for a wakeup.
                    ent[i].busy <= 1'b1;
                    ent[i].op   <= wrOp;
                    ent[i].dest <= wrDest;
                    ent[i].tag1 <= wrTag1;
                    ent[i].tag2 <= wrTag2;
                    ent[i].rdy1 <= wrRdy1 || tag_hit(wrRdy1, wrTag1, cdbValid, cdbTag);
                    ent[i].rdy2 <= wrRdy2 || tag_hit(wrRdy2, wrTag2, cdbValid, cdbTag);
                    ent[i].val1 <= tag_hit(wrRdy1, wrTag1, cdbValid, cdbTag) ? cdbData : wrVal1;
                    ent[i].val2 <= tag_hit(wrRdy2, wrTag2, cdbValid, cdbTag) ? cdbData : wrVal2;
                end else if (ent[i].busy) begin
                    if (fire && sel[i]) ent[i].busy <= 1'b0;
                    if (tag_hit(ent[i].rdy1, ent[i].tag1, cdbValid, cdbTag)) begin
                        ent[i].val1 <= cdbData;
                        ent[i].rdy1 <= 1'b1;
                    end
                    if (tag_hit(ent[i].rdy2, ent[i].tag2, cdbValid, cdbTag)) begin
                        ent[i].val2 <= cdbData;
                        ent[i].rdy2 <= 1'b1;
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_write_free: assert property (@(posedge clk) disable iff (reset || flush)
        (ALURequests & busy_vec) == '0)
        else $error("alu_rs_issue: write to busy entry %b", ALURequests);
    a_write_onehot: assert property (@(posedge clk) disable iff (reset || flush)
        $onehot0(ALURequests))
        else $error("alu_rs_issue: ALURequests not one-hot %b", ALURequests);
`endif

endmodule

// File: tb/tb_alu_rs_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_rs_issue -- directed bench for alu_rs_issue. A per-cycle table of
// input/expected records covers write, wakeup, bypass, flush and reset;
// hand-written sequences cover the full station / issue order and a stalled
// handshake. Expectations follow RS_AGE_ORDER_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_rs_issue;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [3:0]  ALURequests, wrOp, wrDest, wrTag1, wrTag2, cdbTag;
    logic [31:0] wrVal1, wrVal2, cdbData;
    logic        wrRdy1, wrRdy2, cdbValid, issueReady;
    logic [3:0]  ALUBusyVector, issueOp, issueDest, issueIdx;
    logic        issueValid;
    logic [31:0] issueSrc1, issueSrc2;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_fire = 0;

    alu_rs_issue #(.WIDTH(31), .ALU(3), .TAG(3), .OPW(3)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ALURequests(ALURequests),
        .wrOp(wrOp), .wrDest(wrDest), .wrVal1(wrVal1), .wrVal2(wrVal2),
        .wrTag1(wrTag1), .wrTag2(wrTag2), .wrRdy1(wrRdy1), .wrRdy2(wrRdy2),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .ALUBusyVector(ALUBusyVector), .issueValid(issueValid),
        .issueReady(issueReady), .issueOp(issueOp), .issueSrc1(issueSrc1),
        .issueSrc2(issueSrc2), .issueDest(issueDest), .issueIdx(issueIdx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (issueValid && issueReady) n_fire++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst, fl;
        logic [3:0]  req, op, dest;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
        logic        r1, r2, cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic        ir;
        logic [3:0]  e_busy;
        logic        e_valid;
        logic [3:0]  e_idx, e_op, e_dest;
        logic [31:0] e_s1, e_s2;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, fl, input logic [3:0] req, op, dest,
        input logic [31:0] v1, v2, input logic [3:0] t1, t2,
        input logic r1, r2, cv, input logic [3:0] ct, input logic [31:0] cd,
        input logic ir, input logic [3:0] e_busy, input logic e_valid,
        input logic [3:0] e_idx, e_op, e_dest, input logic [31:0] e_s1, e_s2);
        vec_t v;
        v.rst = rst; v.fl = fl; v.req = req; v.op = op; v.dest = dest;
        v.v1 = v1; v.v2 = v2; v.t1 = t1; v.t2 = t2; v.r1 = r1; v.r2 = r2;
        v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir;
        v.e_busy = e_busy; v.e_valid = e_valid; v.e_idx = e_idx;
        v.e_op = e_op; v.e_dest = e_dest; v.e_s1 = e_s1; v.e_s2 = e_s2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; flush = v.fl; ALURequests = v.req; wrOp = v.op;
        wrDest = v.dest; wrVal1 = v.v1; wrVal2 = v.v2; wrTag1 = v.t1;
        wrTag2 = v.t2; wrRdy1 = v.r1; wrRdy2 = v.r2; cdbValid = v.cv;
        cdbTag = v.ct; cdbData = v.cd; issueReady = v.ir;
    endtask

    task automatic idle(input logic ir);
        reset = 0; flush = 0; ALURequests = '0; wrOp = '0; wrDest = '0;
        wrVal1 = '0; wrVal2 = '0; wrTag1 = '0; wrTag2 = '0; wrRdy1 = 0;
        wrRdy2 = 0; cdbValid = 0; cdbTag = '0; cdbData = '0; issueReady = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] req, op, dest, input logic [31:0] v1, v2,
                      input logic [3:0] t1, input logic r1);
        idle(1'b0);
        ALURequests = req; wrOp = op; wrDest = dest; wrVal1 = v1; wrVal2 = v2;
        wrTag1 = t1; wrRdy1 = r1; wrRdy2 = 1'b1;
    endtask

    vec_t tbl [21];
    logic [3:0]  first_idx, second_idx, busy_after1;
    logic [31:0] first_s1, second_s1;
    int          fire0;

    initial begin
        idle(1'b0);
        reset = 1'b1;
        //             rst fl req    op dest v1     v2     t1 t2 r1 r2 cv ct cd     ir | busy   vl idx    op dest s1     s2
        tbl[0]  = mk(1, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     0, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[1]  = mk(0, 0, 4'b0001, 1, 3, 5,     7,     0, 0, 1, 1, 0, 0, 0,     1, 4'b0001, 1, 4'b0001, 1, 3, 5,     7);
        tbl[2]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[3]  = mk(0, 0, 4'b0010, 2, 5, 0,     'h10,  9, 0, 0, 1, 0, 0, 0,     1, 4'b0010, 0, 0,      0, 0, 0,     0);
        tbl[4]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0010, 0, 0,      0, 0, 0,     0);
        tbl[5]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 1, 8, 'h33,  1, 4'b0010, 0, 0,      0, 0, 0,     0);
        tbl[6]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0010, 0, 0,      0, 0, 0,     0);
        tbl[7]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 1, 9, 'hAA,  1, 4'b0010, 1, 4'b0010, 2, 5, 'hAA, 'h10);
        tbl[8]  = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[9]  = mk(0, 0, 4'b0100, 3, 7, 'h11,  0,     0, 4, 1, 0, 1, 4, 'h55,  1, 4'b0100, 1, 4'b0100, 3, 7, 'h11, 'h55);
        tbl[10] = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[11] = mk(0, 0, 4'b0001, 5, 1, 0,     0,     1, 0, 0, 1, 0, 0, 0,     0, 4'b0001, 0, 0,      0, 0, 0,     0);
        tbl[12] = mk(0, 0, 4'b0010, 5, 1, 0,     0,     2, 0, 0, 1, 0, 0, 0,     0, 4'b0011, 0, 0,      0, 0, 0,     0);
        tbl[13] = mk(0, 0, 4'b0100, 5, 1, 0,     0,     3, 0, 0, 1, 0, 0, 0,     0, 4'b0111, 0, 0,      0, 0, 0,     0);
        tbl[14] = mk(0, 1, 4'b1000, 5, 1, 1,     2,     0, 0, 1, 1, 0, 0, 0,     0, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[15] = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     0, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[16] = mk(0, 0, 4'b1000, 6, 2, 0,     0,     6, 6, 0, 0, 0, 0, 0,     0, 4'b1000, 0, 0,      0, 0, 0,     0);
        tbl[17] = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 1, 6, 'h77,  0, 4'b1000, 1, 4'b1000, 6, 2, 'h77, 'h77);
        tbl[18] = mk(0, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0000, 0, 0,      0, 0, 0,     0);
        tbl[19] = mk(0, 0, 4'b0001, 7, 4, 1,     2,     0, 0, 1, 1, 0, 0, 0,     0, 4'b0001, 1, 4'b0001, 7, 4, 1,     2);
        tbl[20] = mk(1, 0, 4'b0000, 0, 0, 0,     0,     0, 0, 0, 0, 0, 0, 0,     1, 4'b0000, 0, 0,      0, 0, 0,     0);

        #2;
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i]);
            tick();
            chk($sformatf("row%0d busy", i), {28'd0, ALUBusyVector}, {28'd0, tbl[i].e_busy});
            chk($sformatf("row%0d valid", i), {31'd0, issueValid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d idx", i), {28'd0, issueIdx}, {28'd0, tbl[i].e_idx});
                chk($sformatf("row%0d op", i), {28'd0, issueOp}, {28'd0, tbl[i].e_op});
                chk($sformatf("row%0d dest", i), {28'd0, issueDest}, {28'd0, tbl[i].e_dest});
                chk($sformatf("row%0d src1", i), issueSrc1, tbl[i].e_s1);
                chk($sformatf("row%0d src2", i), issueSrc2, tbl[i].e_s2);
            end
        end

        // Full station, written 3,2,1,0, none ready; wake 3 then 0.
        wr(4'b1000, 1, 3, 0, 3, 13, 0); tick();
        wr(4'b0100, 1, 2, 0, 2, 12, 0); tick();
        wr(4'b0010, 1, 1, 0, 1, 11, 0); tick();
        wr(4'b0001, 1, 0, 0, 0, 10, 0); tick();
        idle(1'b0); tick();
        chk("full busy", {28'd0, ALUBusyVector}, 32'hF);
        chk("full valid", {31'd0, issueValid}, 32'd0);
        idle(1'b0); cdbValid = 1; cdbTag = 13; cdbData = 'h300; tick();
        chk("wake3 valid", {31'd0, issueValid}, 32'd1);
        chk("wake3 idx", {28'd0, issueIdx}, 32'b1000);
        chk("wake3 src1", issueSrc1, 32'h300);
        idle(1'b0); cdbValid = 1; cdbTag = 10; cdbData = 'h100; tick();
`ifdef RS_AGE_ORDER_EN
        first_idx = 4'b1000; first_s1 = 'h300; second_idx = 4'b0001; second_s1 = 'h100;
        busy_after1 = 4'b0111;
`else
        first_idx = 4'b0001; first_s1 = 'h100; second_idx = 4'b1000; second_s1 = 'h300;
        busy_after1 = 4'b1110;
`endif
        chk("order first idx", {28'd0, issueIdx}, {28'd0, first_idx});
        chk("order first src1", issueSrc1, first_s1);
        idle(1'b1); tick();
        chk("order busy after 1", {28'd0, ALUBusyVector}, {28'd0, busy_after1});
        chk("order second idx", {28'd0, issueIdx}, {28'd0, second_idx});
        chk("order second src1", issueSrc1, second_s1);
        idle(1'b1); tick();
        chk("order busy after 2", {28'd0, ALUBusyVector}, 32'b0110);
        chk("order valid after 2", {31'd0, issueValid}, 32'd0);
        idle(1'b0); reset = 1'b1; tick();
        chk("reset after order", {28'd0, ALUBusyVector}, 32'd0);

        // Stalled handshake: offer held four cycles, then exactly one issue.
        wr(4'b0010, 4, 9, 'hA1, 'hA2, 0, 1); tick();
        fire0 = n_fire;
        for (int c = 0; c < 4; c++) begin
            idle(1'b0); tick();
            chk($sformatf("stall%0d valid", c), {31'd0, issueValid}, 32'd1);
            chk($sformatf("stall%0d idx", c), {28'd0, issueIdx}, 32'b0010);
            chk($sformatf("stall%0d busy", c), {28'd0, ALUBusyVector}, 32'b0010);
            chk($sformatf("stall%0d src", c), issueSrc1 ^ issueSrc2, 32'hA1 ^ 32'hA2);
            chk($sformatf("stall%0d dest", c), {28'd0, issueDest}, 32'd9);
        end
        idle(1'b1); tick();
        chk("stall release busy", {28'd0, ALUBusyVector}, 32'd0);
        chk("stall release valid", {31'd0, issueValid}, 32'd0);
        idle(1'b1); tick();
        chk("stall issue count", n_fire - fire0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
